memory_game_engine: RTL and testbench

MEMORY_GAME_ENGINE -- requirements
Module: memory_game_engine

---
 rtl/memory_game_pkg.sv | 21 ++
 rtl/memory_game_divider.sv | 55 +++++
 rtl/memory_game_engine.sv | 146 ++++++++++++++
 tb/tb_memory_game_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_game_pkg.sv
// memory_game_pkg: shared state encoding, LFSR constants and percentage scale for the memory game.
package memory_game_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GEN    = 3'd1,
        SHOW   = 3'd2,
        GAP    = 3'd3,
        INPUT  = 3'd4,
        DIV    = 3'd5,
        RESULT = 3'd6
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [14:0] PCT_SCALE = 15'd100;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/memory_game_divider.sv
// memory_game_divider: restoring sequential divider, done pulses 16 cycles after start.
module memory_game_divider
    import memory_game_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [14:0] dividend,
    input  logic [8:0]  divisor,
    output logic [6:0]  quotient,
    output logic        done
);
    logic [14:0] quo_q, quo_d;
    logic [8:0]  rem_q, rem_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [9:0]  shifted;
    logic        ge;

    always_comb begin
        shifted = {rem_q, quo_q[14]};
        ge      = shifted >= {1'b0, divisor};
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            cnt_d = 4'd15;
        end else if (cnt_q != 4'd0) begin
            rem_d  = 9'(ge ? shifted - {1'b0, divisor} : shifted);
            quo_d  = {quo_q[13:0], ge};
            cnt_d  = cnt_q - 4'd1;
            done_d = cnt_q == 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q[6:0];
    assign done     = done_q;
endmodule

// File: rtl/memory_game_engine.sv
// memory_game_engine: shows a growing LFSR-generated LED sequence, scores one-hot guesses and reports hit percentage.
module memory_game_engine
    import memory_game_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int DEPTH    = 16,
    parameter int SHOW_CYC = 25000000,
    parameter int GAP_CYC  = 12500000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       enter,
    input  logic                       next,
    input  logic [WIDTH-1:0]           sw,
    output logic [WIDTH-1:0]           led,
    output logic [7:0]                 correct,
    output logic [7:0]                 wrong,
    output logic [6:0]                 percent,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [2:0]                 state,
    output logic                       done
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = $clog2(WIDTH);
    localparam int TW = $clog2((SHOW_CYC > GAP_CYC ? SHOW_CYC : GAP_CYC) + 1);

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [LW-1:0]   level_q, level_d, k_q, k_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      correct_q, correct_d, wrong_q, wrong_d;
    logic [6:0]      percent_q, percent_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic            mem_we, div_start, div_done, last, show_end, gap_end;
    logic [WIDTH-1:0] cur;
    logic [6:0]      div_q;

    assign cur      = WIDTH'(1) << mem_q[k_q[AW-1:0]];
    assign last     = (k_q + 1'b1) == level_q;
    assign show_end = timer_q == TW'(SHOW_CYC - 1);
    assign gap_end  = timer_q == TW'(GAP_CYC - 1);

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_step(lfsr_q);
        level_d   = level_q;
        k_d       = k_q;
        timer_d   = timer_q;
        correct_d = correct_q;
        wrong_d   = wrong_q;
        percent_d = percent_q;
        mem_we    = 1'b0;
        div_start = 1'b0;
        if (start) begin
            state_d   = GEN;
            level_d   = LW'(1);
            k_d       = '0;
            timer_d   = '0;
            correct_d = '0;
            wrong_d   = '0;
        end else begin
            case (state_q)
                GEN: begin
                    mem_we  = 1'b1;
                    k_d     = '0;
                    timer_d = '0;
                    state_d = SHOW;
                end
                SHOW: begin
                    timer_d = show_end ? '0 : timer_q + 1'b1;
                    state_d = show_end ? GAP : SHOW;
                end
                GAP: begin
                    timer_d = gap_end ? '0 : timer_q + 1'b1;
                    k_d     = gap_end ? (last ? '0 : k_q + 1'b1) : k_q;
                    state_d = gap_end ? (last ? INPUT : SHOW) : GAP;
                end
                INPUT: if (enter) begin
                    correct_d = (sw == cur && correct_q != 8'hFF) ? correct_q + 8'd1 : correct_q;
                    wrong_d   = (sw != cur && wrong_q != 8'hFF) ? wrong_q + 8'd1 : wrong_q;
                    k_d       = last ? '0 : k_q + 1'b1;
                    state_d   = last ? DIV : INPUT;
                    div_start = last;
                end
                DIV: if (div_done) begin
                    percent_d = div_q;
                    state_d   = RESULT;
                end
                RESULT: if (next) begin
                    level_d = level_q < LW'(DEPTH) ? level_q + 1'b1 : level_q;
                    state_d = level_q < LW'(DEPTH) ? GEN : SHOW;
                    k_d     = '0;
                    timer_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            level_q   <= '0;
            k_q       <= '0;
            timer_q   <= '0;
            correct_q <= '0;
            wrong_q   <= '0;
            percent_q <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            level_q   <= level_d;
            k_q       <= k_d;
            timer_q   <= timer_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            percent_q <= percent_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem_q[AW'(level_q - 1'b1)] <= EW'(lfsr_q[7:0] % 8'(WIDTH));
    end

    // Started on the final guess so the result lands 16 cycles into DIV
    memory_game_divider u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (PCT_SCALE * 15'(correct_d)),
        .divisor  (9'(correct_d) + 9'(wrong_d)),
        .quotient (div_q),
        .done     (div_done)
    );

    assign led     = state_q == SHOW ? cur : '0;
    assign correct = correct_q;
    assign wrong   = wrong_q;
    assign percent = percent_q;
    assign level   = level_q;
    assign state   = state_q;
    assign done    = state_q == RESULT;
endmodule

// File: tb/tb_memory_game_engine.sv
// tb_memory_game_engine: directed game flow with random guesses checked against a behavioural score model.
module tb_memory_game_engine;
    localparam int W = 4, D = 4, SC = 3, GC = 2;

    logic         clock = 1'b0, reset = 1'b1, start = 1'b0, enter = 1'b0, next = 1'b0;
    logic [W-1:0] sw = '0;
    logic [W-1:0] led;
    logic [7:0]   correct, wrong;
    logic [6:0]   percent;
    logic [2:0]   level;
    logic [2:0]   state;
    logic         done;

    memory_game_engine #(.WIDTH(W), .DEPTH(D), .SHOW_CYC(SC), .GAP_CYC(GC)) dut (
        .clock(clock), .reset(reset), .start(start), .enter(enter), .next(next), .sw(sw),
        .led(led), .correct(correct), .wrong(wrong), .percent(percent), .level(level),
        .state(state), .done(done)
    );

    always #5 clock = ~clock;

    int errs = 0, checks = 0;
    int seq[$];
    int m_c = 0, m_w = 0, m_pct = 0, m_lvl = 0, total = 0;
    logic [15:0] m_lfsr;

    always @(posedge clock or posedge reset)
        m_lfsr <= reset ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] oh(input int e);
        return 4'b0001 << e;
    endfunction

    task automatic gen_step();
        chk("gen_state", state, 1);
        chk("gen_led", led, 0);
        seq.push_back(int'(m_lfsr[7:0]) % W);
        tick();
    endtask

    task automatic show_seq(input bit poke);
        for (int i = 0; i < seq.size(); i++) begin
            for (int j = 0; j < SC; j++) begin
                chk("show_state", state, 2);
                chk("show_led", led, oh(seq[i]));
                enter = poke && i == 0 && j == 0;
                sw = oh(seq[0]);
                tick();
                enter = 1'b0;
            end
            for (int j = 0; j < GC; j++) begin
                chk("gap_state", state, 3);
                chk("gap_led", led, 0);
                tick();
            end
        end
        chk("input_state", state, 4);
        chk("input_correct", correct, m_c);
        chk("input_wrong", wrong, m_w);
        chk("input_done", done, 0);
    endtask

    task automatic play(input logic [3:0] okmask);
        logic [W-1:0] v;
        for (int i = 0; i < seq.size(); i++) begin
            v = W'($urandom_range(0, 15));
            if (v == oh(seq[i])) v = v ^ 4'b0011;
            if (okmask[i]) v = oh(seq[i]);
            if (v == oh(seq[i])) m_c = m_c < 255 ? m_c + 1 : 255;
            else m_w = m_w < 255 ? m_w + 1 : 255;
            sw = v;
            enter = 1'b1;
            tick();
            enter = 1'b0;
        end
        chk("div_enter", state, 5);
        for (int n = 1; n < 16; n++) begin
            chk("div_hold_pct", percent, m_pct);
            tick();
            chk("div_wait", state, 5);
        end
        tick();
        m_pct = 100 * m_c / (m_c + m_w);
        chk("res_state", state, 6);
        chk("res_done", done, 1);
        chk("res_percent", percent, m_pct);
        chk("res_correct", correct, m_c);
        chk("res_wrong", wrong, m_w);
    endtask

    task automatic do_next();
        next = 1'b1;
        tick();
        next = 1'b0;
        if (m_lvl < D) begin
            m_lvl++;
            chk("next_level", level, m_lvl);
            gen_step();
        end else begin
            chk("replay_level", level, D);
            chk("replay_state", state, 2);
        end
    endtask

    task automatic do_start(input bit with_enter);
        start = 1'b1;
        enter = with_enter;
        tick();
        start = 1'b0;
        enter = 1'b0;
        m_c = 0;
        m_w = 0;
        m_lvl = 1;
        seq.delete();
        chk("start_level", level, 1);
        chk("start_correct", correct, 0);
        chk("start_wrong", wrong, 0);
        gen_step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_state", state, 0);
        chk("rst_led", led, 0);
        chk("rst_correct", correct, 0);
        chk("rst_wrong", wrong, 0);
        chk("rst_percent", percent, 0);
        chk("rst_level", level, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        tick();
        sw = 4'b0001;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        chk("idle_enter_state", state, 0);
        chk("idle_enter_correct", correct, 0);

        do_start(1'b0);
        show_seq(1'b1);
        next = 1'b1;
        tick();
        next = 1'b0;
        chk("input_next_state", state, 4);
        chk("input_next_level", level, 1);
        play(4'b0001);
        chk("lvl1_percent", percent, 100);
        sw = oh(seq[0]);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        chk("result_enter_state", state, 6);
        chk("result_enter_correct", correct, 1);

        do_next();
        show_seq(1'b0);
        play(4'b0001);
        chk("lvl2_percent", percent, 66);
        do_next();
        show_seq(1'b0);
        play(4'($urandom));
        do_next();
        show_seq(1'b0);
        play(4'($urandom));
        do_next();
        show_seq(1'b0);
        play(4'($urandom));

        do_next();
        show_seq(1'b0);
        sw = oh(seq[0]);
        do_start(1'b1);
        chk("start_enter_state", state, 2);

        total = 0;
        show_seq(1'b0);
        play(4'hF);
        total += seq.size();
        while (total < 256) begin
            do_next();
            show_seq(1'b0);
            play(4'hF);
            total += seq.size();
        end
        chk("sat_correct", correct, 255);
        chk("sat_wrong", wrong, 0);
        chk("sat_percent", percent, 100);

        do_start(1'b0);
        tick();
        chk("mid_show_state", state, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_led", led, 0);
        chk("async_rst_correct", correct, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_percent", percent, 0);
        chk("async_rst_done", done, 0);
        reset = 1'b0;
        m_pct = 0;
        tick();
        do_start(1'b0);
        show_seq(1'b0);
        play(4'b0001);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
